cc1200spi_regs_fifo: RTL
========================

Name: cc1200spi_regs_fifo

Overview:
Parametrised APB register slave for the CC1200 SPI engine. Adds a TX FIFO that auto-launches SPI words and an RX FIFO that captures returned words. Also adds W1C interrupt status with an enable mask and an irq output, plus parametrised GPIO width. Sits between the APB interconnect and the CC1200 SPI shift engine (Start/Busy/DataOut/DataIn handshake).

Parameters:
DATA_W, 32, SPI word width (≤32).
FIFO_DEPTH, 8, entries per FIFO; power of 2, 2..64.
GPIO_W, 4, GPIO pin count (≤8).
CLKDIV_W, 16, clock divider width (≤32).

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
APB_S_0_paddr  in  32  address; bits [7:0] decoded
APB_S_0_psel / APB_S_0_penable / APB_S_0_pwrite  in  1  APB controls
APB_S_0_pwdata  in  32  write data
APB_S_0_prdata  out  32  read data
APB_S_0_pready  out  1  transfer complete
APB_S_0_pslverr  out  1  error, valid with pready
Start  out  1  one-cycle launch pulse to the SPI engine
Busy  in  1  SPI engine busy
DataOut  out  DATA_W  word being sent
DataIn  in  DATA_W  word received; valid at the Busy falling edge
WR  out  4  write/read mode field
ClockDiv  out  CLKDIV_W  SPI clock divider
GPIO_OutEn / GPIO_Out  out  GPIO_W  GPIO drive enable / value
GPIO_In  in  GPIO_W  async GPIO inputs
Trans  out  1  transaction-hold (CS hold) flag
Irq  out  1  level interrupt

Behaviour:
- Reset: all registers, FIFO pointers, FSM and outputs go to 0. Both FIFOs are empty. Reset mid-transfer abandons the word; no capture occurs.
- APB timing: exactly one wait state.
  - The first access cycle (psel & penable) has pready=0. The next cycle has pready=1.
  - All side effects (register write, FIFO push/pop, W1C) happen only on the pready=1 cycle.
  - pready returns to 0 the following cycle. pslverr is 0 except in the error cases below.
- Register map (offsets):
  - 0x00 CTRL, RW:
    - [0] EN: auto-launch.
    - [1] Trans.
    - [2] TXFLUSH, [3] RXFLUSH: self-clearing, read as 0.
  - 0x04 STATUS, RO: [0] Busy, [1] tx_empty, [2] tx_full, [3] rx_empty, [4] rx_full, [14:8] tx_level, [22:16] rx_level.
  - 0x08 TXDATA, WO:
    - Pushes pwdata[DATA_W-1:0].
    - Write when full: data dropped, pslverr=1, INT_STAT[2] set.
    - Reads as 0.
  - 0x0C RXDATA, RO:
    - Returns the head entry and pops it.
    - Read when empty: prdata=0, pslverr=1, no pointer change.
  - 0x10 WR[3:0], 0x14 ClockDiv, 0x18 GPIO_OutEn, 0x1C GPIO_Out: RW, zero-extended on read.
  - 0x20 GPIO_IN, RO: 2-flop synchronised GPIO_In.
  - 0x24 INT_STAT, W1C:
    - [0] DONE: a word was captured.
    - [1] TX_DRAINED: TX FIFO went empty through a launch pop.
    - [2] TX_OVF.
    - A set event in the same cycle as a W1C of that bit: the set wins.
  - 0x28 INT_EN, RW [2:0].
  - Unmapped offsets: read 0, writes ignored, pslverr=0.
- Irq = |(INT_STAT & INT_EN), registered (1-cycle latency).
- Launch FSM:
  - IDLE: go to LAUNCH when EN & !tx_empty & !rx_full & !Busy. rx_full stalls launch, so RX never overflows.
  - LAUNCH (1 cycle): DataOut <= TX head; pop TX; Start=1 for this cycle only.
  - WAIT_BUSY: wait for Busy=1 → RUN.
  - RUN: on Busy=0 → CAPTURE.
  - CAPTURE (1 cycle): push DataIn into RX; set INT_STAT[0] → IDLE.
  - Minimum gap between back-to-back Start pulses: 4 cycles.
- DataOut holds its value until the next LAUNCH.
- Clearing EN mid-word: the current word completes and is captured; no further launch occurs.
- TXFLUSH during RUN empties the TX FIFO only; the in-flight word completes.
- RXFLUSH in the same cycle as a CAPTURE: the flush wins and the captured word is discarded.
- Simultaneous TX push (APB) and pop (LAUNCH):
  - Both occur and the level is unchanged.
  - The full check uses the pre-pop level, so a push against a full FIFO errors even if a pop occurs in the same cycle.
- Simultaneous RX push (CAPTURE) and APB pop: both occur.
- Levels count 0..FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits plus one wrap bit.

Test Plan:
1. Reset, then read 0x04 → 0x0000000A (tx_empty, rx_empty); read 0x00 → 0; Irq=0; each APB access shows pready high exactly on the 2nd access cycle.
2. Write 0x11,0x22,0x33 to 0x08, then write 0x00=1. A Busy model (3 cycles high, DataIn=~DataOut) sees three Start pulses carrying DataOut 0x11,0x22,0x33. Then read 0x0C ×3 → 0xFFFFFFEE, 0xFFFFFFDD, 0xFFFFFFCC, and the 4th read gives pslverr=1.
3. EN=0; push FIFO_DEPTH+1 words → the last write has pslverr=1; STATUS tx_full=1, tx_level=8; INT_STAT=0x4; with INT_EN=0x4, Irq=1; write 0x24=0x4 → Irq=0.
4. Fill RX to 8 with EN=1 and TX holding 2 words → no Start while rx_full; one RXDATA pop → next Start within 2 cycles.
5. Assert rstn=0 while in RUN → all outputs 0 immediately and both FIFOs empty; after release, Start stays 0 until EN is written.
6. Write 0x00=0x4 (TXFLUSH) during RUN with 3 queued → in-flight word still captured; tx_level=0; CTRL reads back 0x0.

Source files
------------

// File: rtl/cc1200spi_regs_fifo.sv
// APB register slave for the CC1200 SPI engine.
// Holds the TX FIFO that auto-launches SPI words, the RX FIFO that catches
// the returned words, W1C interrupt status with enable mask, and GPIO/clock
// control registers. One APB wait state on every access.
`timescale 1ns/1ps
module cc1200spi_regs_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GPIO_W     = 4,
    parameter int unsigned CLKDIV_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [31:0]         APB_S_0_paddr,
    input  logic                APB_S_0_psel,
    input  logic                APB_S_0_penable,
    input  logic                APB_S_0_pwrite,
    input  logic [31:0]         APB_S_0_pwdata,
    output logic [31:0]         APB_S_0_prdata,
    output logic                APB_S_0_pready,
    output logic                APB_S_0_pslverr,
    output logic                Start,
    input  logic                Busy,
    output logic [DATA_W-1:0]   DataOut,
    input  logic [DATA_W-1:0]   DataIn,
    output logic [3:0]          WR,
    output logic [CLKDIV_W-1:0] ClockDiv,
    output logic [GPIO_W-1:0]   GPIO_OutEn,
    output logic [GPIO_W-1:0]   GPIO_Out,
    input  logic [GPIO_W-1:0]   GPIO_In,
    output logic                Trans,
    output logic                Irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StRun,
        StCapture
    } state_e;

    state_e state_q, state_d;
    logic   launch_go;

    logic                pready_q;
    logic                ctrl_en_q, trans_q;
    logic [3:0]          wr_q;
    logic [CLKDIV_W-1:0] clkdiv_q;
    logic [GPIO_W-1:0]   gpio_oe_q, gpio_out_q, gpio_s1_q, gpio_s2_q;
    logic [2:0]          int_stat_q, int_en_q;
    logic                irq_q;
    logic [DATA_W-1:0]   data_out_q;

    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    ptr_t tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    ptr_t tx_level, rx_level;
    logic tx_empty, tx_full, rx_empty, rx_full;

    logic [7:0] addr;
    logic       acc, wr_acc, rd_acc;
    logic       ctrl_wr, tx_flush, rx_flush;
    logic       tx_push_req, tx_push, tx_ovf, tx_pop;
    logic       rx_pop, rx_push;
    logic [2:0] int_set, int_w1c;

    logic [31:0] rdata;
    logic        rerr;
    logic [31:0] clkdiv_ext, gpio_oe_ext, gpio_out_ext, gpio_in_ext, rx_head_ext, status;

    logic unused_paddr;
    assign unused_paddr = ^APB_S_0_paddr[31:8];

    // FIFO occupancy; pointers carry one wrap bit above the index
    assign tx_level = tx_wr_q - tx_rd_q;
    assign rx_level = rx_wr_q - rx_rd_q;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign tx_full  = (tx_level == ptr_t'(FIFO_DEPTH));
    assign rx_full  = (rx_level == ptr_t'(FIFO_DEPTH));

    // APB decode: side effects only on the pready cycle
    always_comb begin
        addr        = APB_S_0_paddr[7:0];
        acc         = APB_S_0_psel & APB_S_0_penable & pready_q;
        wr_acc      = acc & APB_S_0_pwrite;
        rd_acc      = acc & ~APB_S_0_pwrite;
        ctrl_wr     = wr_acc && (addr == 8'h00);
        tx_flush    = ctrl_wr & APB_S_0_pwdata[2];
        rx_flush    = ctrl_wr & APB_S_0_pwdata[3];
        tx_push_req = wr_acc && (addr == 8'h08);
        // full check uses the pre-pop level
        tx_push     = tx_push_req & ~tx_full;
        tx_ovf      = tx_push_req & tx_full;
        rx_pop      = rd_acc && (addr == 8'h0C) && !rx_empty;
        tx_pop      = (state_q == StLaunch) && !tx_empty && !tx_flush;
        // flush discards a word captured in the same cycle
        rx_push     = (state_q == StCapture) && !rx_flush && !rx_full;
        int_set[0]  = (state_q == StCapture);
        int_set[1]  = tx_pop && (tx_level == ptr_t'(1)) && !tx_push;
        int_set[2]  = tx_ovf;
        int_w1c     = (wr_acc && (addr == 8'h24)) ? APB_S_0_pwdata[2:0] : 3'b000;
    end

    // Launch FSM next state
    always_comb begin
        state_d   = state_q;
        launch_go = 1'b0;
        case (state_q)
            StIdle: begin
                if (ctrl_en_q && !tx_empty && !rx_full && !Busy && !tx_flush) begin
                    state_d   = StLaunch;
                    launch_go = 1'b1;
                end
            end
            StLaunch:   state_d = StWaitBusy;
            StWaitBusy: if (Busy) state_d = StRun;
            StRun:      if (!Busy) state_d = StCapture;
            StCapture:  state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM state and the word presented to the engine (loaded so it is valid with Start)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch_go) data_out_q <= tx_mem[tx_rd_q[AW-1:0]];
        end
    end

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= APB_S_0_pwdata[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= DataIn;
    end

    // FIFO pointers; a flush overrides a same-cycle pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + ptr_t'(1);
            if (tx_flush) tx_rd_q <= tx_wr_q;
            else if (tx_pop) tx_rd_q <= tx_rd_q + ptr_t'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + ptr_t'(1);
            if (rx_flush) rx_rd_q <= rx_wr_q;
            else if (rx_pop) rx_rd_q <= rx_rd_q + ptr_t'(1);
        end
    end

    // APB handshake plus control/config registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pready_q   <= 1'b0;
            ctrl_en_q  <= 1'b0;
            trans_q    <= 1'b0;
            wr_q       <= '0;
            clkdiv_q   <= '0;
            gpio_oe_q  <= '0;
            gpio_out_q <= '0;
            int_en_q   <= '0;
        end else begin
            pready_q <= APB_S_0_psel & APB_S_0_penable & ~pready_q;
            if (wr_acc) begin
                case (addr)
                    8'h00: begin
                        ctrl_en_q <= APB_S_0_pwdata[0];
                        trans_q   <= APB_S_0_pwdata[1];
                    end
                    8'h10:   wr_q       <= APB_S_0_pwdata[3:0];
                    8'h14:   clkdiv_q   <= APB_S_0_pwdata[CLKDIV_W-1:0];
                    8'h18:   gpio_oe_q  <= APB_S_0_pwdata[GPIO_W-1:0];
                    8'h1C:   gpio_out_q <= APB_S_0_pwdata[GPIO_W-1:0];
                    8'h28:   int_en_q   <= APB_S_0_pwdata[2:0];
                    default: ;
                endcase
            end
        end
    end

    // Interrupt status (set beats W1C), registered irq, GPIO input synchroniser
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            int_stat_q <= '0;
            irq_q      <= 1'b0;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
        end else begin
            int_stat_q <= (int_stat_q & ~int_w1c) | int_set;
            irq_q      <= |(int_stat_q & int_en_q);
            gpio_s1_q  <= GPIO_In;
            gpio_s2_q  <= gpio_s1_q;
        end
    end

    // Zero-extended views of narrow fields for the read mux
    always_comb begin
        clkdiv_ext                    = '0;
        clkdiv_ext[CLKDIV_W-1:0]      = clkdiv_q;
        gpio_oe_ext                   = '0;
        gpio_oe_ext[GPIO_W-1:0]       = gpio_oe_q;
        gpio_out_ext                  = '0;
        gpio_out_ext[GPIO_W-1:0]      = gpio_out_q;
        gpio_in_ext                   = '0;
        gpio_in_ext[GPIO_W-1:0]       = gpio_s2_q;
        rx_head_ext                   = '0;
        rx_head_ext[DATA_W-1:0]       = rx_mem[rx_rd_q[AW-1:0]];
        status                        = '0;
        status[0]                     = Busy;
        status[1]                     = tx_empty;
        status[2]                     = tx_full;
        status[3]                     = rx_empty;
        status[4]                     = rx_full;
        status[14:8]                  = 7'(tx_level);
        status[22:16]                 = 7'(rx_level);
    end

    // Read data and error response, driven only on the pready cycle
    always_comb begin
        rdata = '0;
        rerr  = 1'b0;
        if (rd_acc) begin
            case (addr)
                8'h00:   rdata = {30'b0, trans_q, ctrl_en_q};
                8'h04:   rdata = status;
                8'h0C: begin
                    if (rx_empty) rerr = 1'b1;
                    else rdata = rx_head_ext;
                end
                8'h10:   rdata = {28'b0, wr_q};
                8'h14:   rdata = clkdiv_ext;
                8'h18:   rdata = gpio_oe_ext;
                8'h1C:   rdata = gpio_out_ext;
                8'h20:   rdata = gpio_in_ext;
                8'h24:   rdata = {29'b0, int_stat_q};
                8'h28:   rdata = {29'b0, int_en_q};
                default: rdata = '0;
            endcase
        end
        if (tx_ovf) rerr = 1'b1;
    end

    assign APB_S_0_prdata  = rdata;
    assign APB_S_0_pslverr = rerr;
    assign APB_S_0_pready  = pready_q;
    assign Start           = (state_q == StLaunch);
    assign DataOut         = data_out_q;
    assign WR              = wr_q;
    assign ClockDiv        = clkdiv_q;
    assign GPIO_OutEn      = gpio_oe_q;
    assign GPIO_Out        = gpio_out_q;
    assign Trans           = trans_q;
    assign Irq             = irq_q;

endmodule
